// File: rtl/alu_pkg.sv
// ALU encodings shared by the core and the shifter.
// Opcode, condition and shift-type constants.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_MUL  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_XOR  = 4'b0101;
  localparam logic [3:0] OP_MOVI = 4'b0110;
  localparam logic [3:0] OP_MOV  = 4'b0111;
  localparam logic [3:0] OP_CMP  = 4'b1011;
  localparam logic [3:0] OP_LDR  = 4'b1101;
  localparam logic [3:0] OP_STR  = 4'b1110;

  localparam logic [3:0] CC_AL = 4'b0000;
  localparam logic [3:0] CC_EQ = 4'b0001;
  localparam logic [3:0] CC_GT = 4'b0010;
  localparam logic [3:0] CC_LT = 4'b0011;
  localparam logic [3:0] CC_GE = 4'b0100;
  localparam logic [3:0] CC_LE = 4'b0101;
  localparam logic [3:0] CC_HI = 4'b0110;
  localparam logic [3:0] CC_LO = 4'b0111;
  localparam logic [3:0] CC_HS = 4'b1000;
  localparam logic [3:0] CC_NE = 4'b1001;

  localparam logic [2:0] SR_NONE = 3'b000;
  localparam logic [2:0] SR_LSR  = 3'b001;
  localparam logic [2:0] SR_LSL  = 3'b010;
  localparam logic [2:0] SR_ROR  = 3'b011;
  localparam logic [2:0] SR_ASR  = 3'b100;

endpackage

// File: rtl/alu_shifter.sv
// Barrel shifter forming Op2 from In2.
// Ports: In2, SR_Cont (type), SR_Bit (amount) -> Op2.
module alu_shifter
  import alu_pkg::*;
(
  input  logic [31:0] In2,
  input  logic [2:0]  SR_Cont,
  input  logic [4:0]  SR_Bit,
  output logic [31:0] Op2
);

  logic [5:0] inv_amt;

  // Left half of a rotate; a 32-bit shift
  // yields 0, so ROR by 0 passes In2.
  assign inv_amt = 6'd32 - {1'b0, SR_Bit};

  always_comb begin
    Op2 = In2;
    case (SR_Cont)
      SR_LSR:  Op2 = In2 >> SR_Bit;
      SR_LSL:  Op2 = In2 << SR_Bit;
      SR_ROR:  Op2 = (In2 >> SR_Bit)
                   | (In2 << inv_amt);
      SR_ASR:  Op2 = $unsigned(
                 $signed(In2) >>> SR_Bit);
      default: Op2 = In2;
    endcase
  end

endmodule

// File: rtl/alu_core.sv
// Conditional ALU with registered result/flags.
// Ports: clk, rst, In1, In2, Opcode, Cond, SR_Bit, SR_Cont, S, Immediate -> Out, Flags{N,Z,C,V}, Condition_met.
module alu_core
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] In1,
  input  logic [31:0] In2,
  input  logic [3:0]  Opcode,
  input  logic [3:0]  Cond,
  input  logic [4:0]  SR_Bit,
  input  logic [2:0]  SR_Cont,
  input  logic        S,
  input  logic [15:0] Immediate,
  output logic [31:0] Out,
  output logic [3:0]  Flags,
  output logic        Condition_met
);

  logic [31:0] op2;
  logic [32:0] sum;
  logic [32:0] dif;
  logic [3:0]  add_f;
  logic [3:0]  sub_f;
  logic        cn, cz, cc, cv;
  logic        met;
  logic [31:0] res;

  logic [31:0] out_d, out_q;
  logic [3:0]  flags_d, flags_q;
  logic        met_d, met_q;

  alu_shifter u_shifter (
    .In2     (In2),
    .SR_Cont (SR_Cont),
    .SR_Bit  (SR_Bit),
    .Op2     (op2)
  );

  assign sum = {1'b0, In1} + {1'b0, op2};
  assign dif = {1'b0, In1} - {1'b0, op2};

  assign add_f = {
    sum[31],
    sum[31:0] == 32'd0,
    sum[32],
    (In1[31] == op2[31])
      && (sum[31] != In1[31])
  };

  // C is "no borrow" on subtract.
  assign sub_f = {
    dif[31],
    dif[31:0] == 32'd0,
    ~dif[32],
    (In1[31] != op2[31])
      && (dif[31] != In1[31])
  };

  // Condition always comes from the live
  // compare, never from stored flags.
  assign {cn, cz, cc, cv} = sub_f;

  always_comb begin
    met = 1'b1;
    case (Cond)
      CC_EQ:   met = cz;
      CC_GT:   met = ~cz && (cn == cv);
      CC_LT:   met = cn != cv;
      CC_GE:   met = cn == cv;
      CC_LE:   met = cz || (cn != cv);
      CC_HI:   met = cc && ~cz;
      CC_LO:   met = ~cc;
      CC_HS:   met = cc;
      CC_NE:   met = ~cz;
      default: met = 1'b1;
    endcase
  end

  always_comb begin
    res = 32'd0;
    case (Opcode)
      OP_ADD:  res = sum[31:0];
      OP_SUB:  res = dif[31:0];
      OP_MUL:  res = In1 * op2;
      OP_OR:   res = In1 | op2;
      OP_AND:  res = In1 & op2;
      OP_XOR:  res = In1 ^ op2;
      OP_MOVI: res = {16'd0, Immediate};
      OP_MOV:  res = In1;
      OP_LDR:  res = In1;
      OP_STR:  res = In1;
      default: res = 32'd0;
    endcase
  end

  always_comb begin
    met_d   = met;
    out_d   = met ? res : 32'd0;
    flags_d = flags_q;
    if (Opcode == OP_CMP) begin
      flags_d = sub_f;
    end else if (S && met) begin
      if (Opcode == OP_ADD)
        flags_d = add_f;
      else if (Opcode == OP_SUB)
        flags_d = sub_f;
      else
        flags_d = {res[31],
                   res == 32'd0,
                   flags_q[1:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q   <= 32'd0;
      flags_q <= 4'd0;
      met_q   <= 1'b0;
    end else begin
      out_q   <= out_d;
      flags_q <= flags_d;
      met_q   <= met_d;
    end
  end

  assign Out           = out_q;
  assign Flags         = flags_q;
  assign Condition_met = met_q;

endmodule

// File: tb/tb_alu_core.sv
// Self-checking bench for alu_core.
// Directed scenarios plus random ops vs a behavioural model.
module tb_alu_core;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] In1, In2;
  logic [3:0]  Opcode, Cond;
  logic [4:0]  SR_Bit;
  logic [2:0]  SR_Cont;
  logic        S;
  logic [15:0] Immediate;
  logic [31:0] Out;
  logic [3:0]  Flags;
  logic        Condition_met;

  int n_tests = 0;
  int n_fail  = 0;
  logic [3:0] mflags;

  always #5 clk = ~clk;

  alu_core dut (
    .clk           (clk),
    .rst           (rst),
    .In1           (In1),
    .In2           (In2),
    .Opcode        (Opcode),
    .Cond          (Cond),
    .SR_Bit        (SR_Bit),
    .SR_Cont       (SR_Cont),
    .S             (S),
    .Immediate     (Immediate),
    .Out           (Out),
    .Flags         (Flags),
    .Condition_met (Condition_met)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_op2(
      input logic [31:0] v,
      input logic [2:0] t,
      input logic [4:0] n);
    logic [31:0] r;
    r = v;
    case (t)
      3'd1: r = v / (32'd1 << n);
      3'd2: r = v * (32'd1 << n);
      3'd3: repeat (n) r = {r[0], r[31:1]};
      3'd4: r = $signed(v) >>> n;
      default: r = v;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] m_sub(
      input logic [31:0] a,
      input logic [31:0] b);
    logic [31:0] d;
    longint sd;
    d  = a - b;
    sd = longint'($signed(a))
       - longint'($signed(b));
    return {d[31], d == 0, a >= b,
            sd > 64'sd2147483647
            || sd < -64'sd2147483648};
  endfunction

  function automatic logic [3:0] m_add(
      input logic [31:0] a,
      input logic [31:0] b);
    logic [31:0] r;
    longint us, ss;
    r  = a + b;
    us = longint'(a) + longint'(b);
    ss = longint'($signed(a))
       + longint'($signed(b));
    return {r[31], r == 0,
            us > 64'sd4294967295,
            ss > 64'sd2147483647
            || ss < -64'sd2147483648};
  endfunction

  function automatic logic m_cond(
      input logic [3:0] c,
      input logic [31:0] a,
      input logic [31:0] b);
    int sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    case (c)
      4'd1: return a == b;
      4'd2: return sa > sb;
      4'd3: return sa < sb;
      4'd4: return sa >= sb;
      4'd5: return sa <= sb;
      4'd6: return a > b;
      4'd7: return a < b;
      4'd8: return a >= b;
      4'd9: return a != b;
      default: return 1'b1;
    endcase
  endfunction

  // Applies one operation, checks it one
  // edge later, returns the expected Out.
  task automatic step(
      input string tag,
      input logic [3:0] op,
      input logic [3:0] cc,
      input logic [2:0] sc,
      input logic [4:0] sb,
      input logic s_,
      input logic [31:0] a,
      input logic [31:0] b,
      input logic [15:0] imm,
      output logic [31:0] e_out);
    logic [31:0] o2, res;
    logic met;
    logic [3:0] ef;
    In1 = a; In2 = b; Opcode = op;
    Cond = cc; SR_Cont = sc;
    SR_Bit = sb; S = s_; Immediate = imm;
    o2  = m_op2(b, sc, sb);
    met = m_cond(cc, a, o2);
    case (op)
      4'd0:  res = a + o2;
      4'd1:  res = a - o2;
      4'd2:  res = a * o2;
      4'd3:  res = a | o2;
      4'd4:  res = a & o2;
      4'd5:  res = a ^ o2;
      4'd6:  res = {16'd0, imm};
      4'd7, 4'd13, 4'd14: res = a;
      default: res = 32'd0;
    endcase
    e_out = met ? res : 32'd0;
    ef = mflags;
    if (op == 4'd11)
      ef = m_sub(a, o2);
    else if (s_ && met) begin
      if (op == 4'd0)      ef = m_add(a, o2);
      else if (op == 4'd1) ef = m_sub(a, o2);
      else ef = {res[31], res == 0,
                 mflags[1:0]};
    end
    @(posedge clk);
    #1;
    chk({tag, ".out"}, Out, e_out);
    chk({tag, ".flg"}, {28'd0, Flags},
        {28'd0, ef});
    chk({tag, ".met"},
        {31'd0, Condition_met},
        {31'd0, met});
    mflags = ef;
  endtask

  initial begin
    logic [31:0] eo;
    logic [31:0] ra, rb;
    rst = 1'b1; In1 = 0; In2 = 0;
    Opcode = 0; Cond = 0; SR_Bit = 0;
    SR_Cont = 0; S = 0; Immediate = 0;
    mflags = 4'd0;
    @(posedge clk); #1;
    chk("rst.out", Out, 32'd0);
    chk("rst.flg", {28'd0, Flags}, 32'd0);
    chk("rst.met", {31'd0, Condition_met}, 32'd0);
    rst = 1'b0;

    step("add", 0, 0, 0, 0, 0, 15, 20, 0, eo);
    chk("add.k", Out, 32'd35);
    step("sub", 1, 0, 0, 0, 0, 30, 10, 0, eo);
    chk("sub.k", Out, 32'd20);
    step("mul", 2, 0, 0, 0, 0, 5, 5, 0, eo);
    chk("mul.k", Out, 32'd25);
    step("or", 3, 0, 0, 0, 0,
         32'h0A0, 32'h005, 0, eo);
    chk("or.k", Out, 32'h0A5);

    step("lsr", 0, 0, 1, 4, 0, 30, 10, 0, eo);
    chk("lsr.k", Out, 32'd30);
    step("lsl", 0, 0, 2, 4, 0, 30, 10, 0, eo);
    chk("lsl.k", Out, 32'd190);
    step("ror", 0, 0, 3, 4, 0, 30, 10, 0, eo);
    chk("ror.k", Out, 32'hA000001E);

    step("cmp1", 11, 0, 0, 0, 0, 15, 20, 0, eo);
    chk("cmp1.k", {Out, Flags},
        {32'd0, 4'b1000});
    step("cmp2", 11, 0, 0, 0, 0, 5, 5, 0, eo);
    chk("cmp2.k", {Out, Flags},
        {32'd0, 4'b0110});
    step("cmp3", 11, 0, 0, 0, 0, 30, 25, 0, eo);
    chk("cmp3.k", {Out, Flags},
        {32'd0, 4'b0010});
    step("cmp4", 11, 0, 0, 0, 0,
         0, 32'h80000000, 0, eo);
    chk("cmp4.k", {Out, Flags},
        {32'd0, 4'b1001});

    step("eq1", 0, 1, 0, 0, 0, 20, 20, 0, eo);
    chk("eq1.k", {Out, 3'd0, Condition_met},
        {32'd40, 4'd1});
    step("eq0", 0, 1, 0, 0, 0, -10, -11, 0, eo);
    chk("eq0.k", {Out, 3'd0, Condition_met},
        {32'd0, 4'd0});
    step("gt1", 0, 2, 0, 0, 0, 20, 10, 0, eo);
    chk("gt1.k", {31'd0, Condition_met}, 1);
    step("gt0", 0, 2, 0, 0, 0, -10, -5, 0, eo);
    chk("gt0.k", {31'd0, Condition_met}, 0);
    step("hi1", 0, 6, 0, 0, 0, -2, 100, 0, eo);
    chk("hi1.k", {31'd0, Condition_met}, 1);
    step("hi0", 0, 6, 0, 0, 0, 10, 25, 0, eo);
    chk("hi0.k", {31'd0, Condition_met}, 0);
    step("hs1", 0, 8, 0, 0, 0, 13, 13, 0, eo);
    chk("hs1.k", {31'd0, Condition_met}, 1);
    step("hs0", 0, 8, 0, 0, 0, 20, -5, 0, eo);
    chk("hs0.k", {31'd0, Condition_met}, 0);

    step("movi", 6, 0, 0, 0, 0, 7, 9, 60, eo);
    chk("movi.k", Out, 32'd60);
    step("ldr", 13, 0, 0, 0, 0, 30, 1, 0, eo);
    chk("ldr.k", Out, 32'd30);
    step("str", 14, 0, 0, 0, 0, 30, 1, 0, eo);
    chk("str.k", Out, 32'd30);

    step("adds", 0, 0, 0, 0, 1,
         32'hFFFFFFFF, 1, 0, eo);
    In1 = 15; In2 = 20; Opcode = 0;
    Cond = 0; S = 1; rst = 1'b1;
    @(posedge clk); #1;
    chk("mid.out", Out, 32'd0);
    chk("mid.flg", {28'd0, Flags}, 32'd0);
    chk("mid.met", {31'd0, Condition_met}, 32'd0);
    mflags = 4'd0;
    rst = 1'b0;
    step("post", 0, 0, 0, 0, 0, 1, 2, 0, eo);
    chk("post.k", Out, 32'd3);

    for (int i = 0; i < 400; i++) begin
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 2) == 0) begin
        ra = $urandom_range(0, 40) - 20;
        rb = $urandom_range(0, 40) - 20;
      end
      if ($urandom_range(0, 7) == 0) rb = ra;
      step("rnd",
           4'($urandom_range(0, 15)),
           4'($urandom_range(0, 15)),
           3'($urandom_range(0, 7)),
           5'($urandom_range(0, 31)),
           1'($urandom_range(0, 1)),
           ra, rb,
           16'($urandom), eo);
    end

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_core.md
ALU_CORE -- requirements
Module: alu_core

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset, with ports named clk and rst.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 In1  input  32  first operand (Rn).
REQ-005 In2  input  32  second operand, pre-shifted to form Op2.
REQ-006 Opcode  input  4  operation select.
REQ-007 Cond  input  4  execution condition.
REQ-008 SR_Bit  input  5  shift/rotate amount, 0-31.
REQ-009 SR_Cont  input  3  shift type applied to In2.
REQ-010 S  input  1  set-flags enable for non-compare operations.
REQ-011 Immediate  input  16  immediate for MOV-immediate.
REQ-012 Out  output  32  registered result.
REQ-013 Flags  output  4  registered status flags {N,Z,C,V}, with N at bit 3.
REQ-014 Condition_met  output  1  registered condition result.

Function
REQ-015 Op2 SHALL be derived from In2 by SR_Cont:
- 000: pass In2 unchanged.
- 001: logical shift right by SR_Bit.
- 010: logical shift left by SR_Bit.
- 011: rotate right by SR_Bit.
- 100: arithmetic shift right by SR_Bit.
- 101-111: pass In2 unchanged.
REQ-016 Opcode results SHALL be:
- 0000: In1+Op2.
- 0001: In1-Op2.
- 0010: low 32 bits of In1*Op2.
- 0011: In1|Op2.
- 0100: In1&Op2.
- 0101: In1^Op2.
- 0110: zero-extended Immediate.
- 0111: In1.
- 1011 (CMP): 0.
- 1101 (LDR): In1.
- 1110 (STR): In1.
- all others: 0.
REQ-017 Add and subtract SHALL wrap modulo 2^32.
REQ-018 The condition SHALL be evaluated from the compare of the current In1 against Op2 (i.e. In1-Op2), not from stored Flags.
REQ-019 Cond encoding:
- 0000: always.
- 0001: EQ.
- 0010: signed GT.
- 0011: signed LT.
- 0100: signed GE.
- 0101: signed LE.
- 0110: unsigned HI.
- 0111: unsigned LO.
- 1000: unsigned HS.
- 1001: NE.
- 1010-1111: always.
REQ-020 On each rising edge with rst=0, Condition_met SHALL load the evaluated condition.
REQ-021 On the same edge, Out SHALL load the opcode result if the condition is met, otherwise 0; latency is one cycle and there is no handshake.
REQ-022 Flag computation for Opcode 1011 (CMP):
- N and Z come from In1-Op2.
- C=1 when no unsigned borrow (In1>=Op2 unsigned).
- V=signed overflow of the subtraction.
REQ-023 Flag update rules:
- CMP SHALL update Flags regardless of S.
- Other opcodes SHALL update Flags only when S=1 and the condition is met.
- Add/sub set all four flags from their own result.
- All other opcodes set N and Z from the result and hold C and V.
REQ-024 Flags SHALL hold their value in every other case.

Reset
REQ-025 When rst=1 at a rising edge, Out, Flags and Condition_met SHALL all become 0, overriding any operation.
REQ-026 A reset mid-stream SHALL discard that cycle's operation, and the first result after deassertion SHALL appear one edge later.

Structure
REQ-027 Opcode, Cond and SR_Cont encodings SHALL be named constants in a shared package alu_pkg.
REQ-028 The shift/rotate logic SHALL be one sub-module alu_shifter (In2, SR_Cont, SR_Bit -> Op2), and all remaining logic SHALL be in alu_core.

Verification
REQ-029 Directed scenarios, each result checked one edge after applying inputs:
- Cond=0000, ADD 15+20 -> Out=35; SUB 30-10 -> Out=20; MUL 5*5 -> Out=25; OR 0x0A0|0x005 -> 0x0A5.
- ADD In1=30, In2=10, SR_Bit=4, SR_Cont=001 -> Out=30; SR_Cont=010 -> Out=190; SR_Cont=011 -> Out=0xA000001E.
- CMP with S=0 -> Out=0 in every case; Flags:
  - 15 vs 20 -> 1000.
  - 5 vs 5 -> 0110.
  - 30 vs 25 -> 0010.
  - 0 vs 0x80000000 -> 1001.
- Conditions with operand pairs:
  - EQ: 20,20 -> met, Out=40; -10,-11 -> Condition_met=0, Out=0.
  - GT: 20,10 -> met; -10,-5 -> not met.
  - HI: -2,100 -> met; 10,25 -> not met.
  - HS: 13,13 -> met; 20,-5 -> not met.
- MOV-immediate Immediate=60 -> Out=60; LDR/STR In1=30 -> Out=30; assert rst during ADD -> Out=0, Flags=0, Condition_met=0 at next edge.
